golden_dispatch_ctrl: RTL and testbench



---
 rtl/golden_logistics_pkg.sv | 26 ++
 rtl/golden_dispatch_ctrl_if.sv | 43 ++++
 rtl/golden_timeout_timer.sv | 31 +++
 rtl/golden_dispatch_ctrl.sv | 149 ++++++++++++++
 tb/tb_golden_dispatch_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/golden_logistics_pkg.sv
// Shared types, defaults and helpers for the shipment dispatch controller.
// Optional statistics counters are enabled by defining GOLDEN_DISPATCH_STATS_EN.
package golden_logistics_pkg;

   localparam int DEF_ID_W           = 8;
   localparam int DEF_TIMEOUT_CYCLES = 64;
   localparam int DEF_MAX_RETRY      = 2;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      CUSTOMS      = 3'd1,
      WAIT_TRANSIT = 3'd2,
      IN_TRANSIT   = 3'd3,
      REPORT       = 3'd4
   } dispatch_state_e;

   typedef struct packed {
      logic [DEF_ID_W-1:0] id;
      logic                ok;
   } done_status_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/golden_dispatch_ctrl_if.sv
// Order, customs, carrier and completion signals of the dispatch controller.
// Statistics signals exist only when GOLDEN_DISPATCH_STATS_EN is defined.
interface golden_dispatch_ctrl_if
   import golden_logistics_pkg::*;
#(
   parameter int ID_W = DEF_ID_W
);
   logic            order_valid;
   logic            order_ready;
   logic [ID_W-1:0] order_id;
   logic            customs_req;
   logic            customs_cleared;
   logic            transit_ready;
   logic            truck_depart;
   logic            delivery_confirmed;
   logic            done_valid;
   logic [ID_W-1:0] done_id;
   logic            done_ok;
   logic            busy;
`ifdef GOLDEN_DISPATCH_STATS_EN
   logic [15:0]     stat_delivered;
   logic [15:0]     stat_failed;
   logic [15:0]     stat_retries;
`endif

   // master is the environment side, slave is the controller
   modport master (
      output order_valid, order_id, customs_cleared, transit_ready, delivery_confirmed,
      input  order_ready, customs_req, truck_depart, done_valid, done_id, done_ok, busy
`ifdef GOLDEN_DISPATCH_STATS_EN
      , input stat_delivered, stat_failed, stat_retries
`endif
   );

   modport slave (
      input  order_valid, order_id, customs_cleared, transit_ready, delivery_confirmed,
      output order_ready, customs_req, truck_depart, done_valid, done_id, done_ok, busy
`ifdef GOLDEN_DISPATCH_STATS_EN
      , output stat_delivered, stat_failed, stat_retries
`endif
   );

endinterface

// File: rtl/golden_timeout_timer.sv
// Saturating in-transit timer: load clears it, enable counts, expired flags TIMEOUT_CYCLES-1.
module golden_timeout_timer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic enable,
   output logic expired
);
   localparam int               CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_r;

   // count enabled cycles since the last load, parking at LAST instead of wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {CNT_W{1'b0}};
      end else if (load) begin
         count_r <= {CNT_W{1'b0}};
      end else if (enable && (count_r != LAST)) begin
         count_r <= count_r + CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = (count_r == LAST);

endmodule

// File: rtl/golden_dispatch_ctrl.sv
// Sender-side shipment dispatch controller: customs, launch, confirmation wait, retry, report.
// Define GOLDEN_DISPATCH_STATS_EN to add delivered/failed/retry statistics counters.
module golden_dispatch_ctrl
   import golden_logistics_pkg::*;
#(
   parameter int ID_W           = DEF_ID_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
   input logic                   clk,
   input logic                   rst_n,
   golden_dispatch_ctrl_if.slave bus
);
   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   dispatch_state_e    state_r;
   logic               customs_req_r;
   logic               truck_depart_r;
   logic               done_valid_r;
   logic [ID_W-1:0]    done_id_r;
   logic               done_ok_r;
   logic [ID_W-1:0]    order_id_r;
   logic [RETRY_W-1:0] retry_r;

   logic depart_s;
   logic in_transit_s;
   logic expired_s;
   logic timeout_s;
   logic retry_s;

   golden_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (depart_s),
      .enable  (in_transit_s),
      .expired (expired_s)
   );

   // launch and timeout decisions; confirmation wins over an expiring timer
   always_comb begin
      in_transit_s = (state_r == IN_TRANSIT);
      depart_s     = (state_r == WAIT_TRANSIT) && bus.customs_cleared && bus.transit_ready;
      timeout_s    = in_transit_s && !bus.delivery_confirmed && expired_s;
      retry_s      = timeout_s && (retry_r < RETRY_W'(MAX_RETRY));
   end

   // dispatch state machine with registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= IDLE;
         customs_req_r  <= 1'b0;
         truck_depart_r <= 1'b0;
         done_valid_r   <= 1'b0;
         done_id_r      <= {ID_W{1'b0}};
         done_ok_r      <= 1'b0;
         order_id_r     <= {ID_W{1'b0}};
         retry_r        <= {RETRY_W{1'b0}};
      end else begin
         truck_depart_r <= 1'b0;
         done_valid_r   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.order_valid) begin
                  order_id_r    <= bus.order_id;
                  retry_r       <= {RETRY_W{1'b0}};
                  customs_req_r <= 1'b1;
                  state_r       <= CUSTOMS;
               end
            end
            CUSTOMS: begin
               if (bus.customs_cleared) begin
                  state_r <= WAIT_TRANSIT;
               end
            end
            WAIT_TRANSIT: begin
               if (!bus.customs_cleared) begin
                  state_r <= CUSTOMS;
               end else if (depart_s) begin
                  truck_depart_r <= 1'b1;
                  state_r        <= IN_TRANSIT;
               end
            end
            IN_TRANSIT: begin
               if (bus.delivery_confirmed) begin
                  done_valid_r  <= 1'b1;
                  done_id_r     <= order_id_r;
                  done_ok_r     <= 1'b1;
                  customs_req_r <= 1'b0;
                  state_r       <= REPORT;
               end else if (retry_s) begin
                  retry_r <= retry_r + RETRY_W'(1);
                  state_r <= WAIT_TRANSIT;
               end else if (timeout_s) begin
                  done_valid_r  <= 1'b1;
                  done_id_r     <= order_id_r;
                  done_ok_r     <= 1'b0;
                  customs_req_r <= 1'b0;
                  state_r       <= REPORT;
               end
            end
            REPORT: begin
               state_r <= IDLE;
            end
            default: begin
               customs_req_r <= 1'b0;
               state_r       <= IDLE;
            end
         endcase
      end
   end

   assign bus.order_ready  = (state_r == IDLE);
   assign bus.busy         = (state_r != IDLE);
   assign bus.customs_req  = customs_req_r;
   assign bus.truck_depart = truck_depart_r;
   assign bus.done_valid   = done_valid_r;
   assign bus.done_id      = done_id_r;
   assign bus.done_ok      = done_ok_r;

`ifdef GOLDEN_DISPATCH_STATS_EN
   logic [15:0] stat_delivered_r;
   logic [15:0] stat_failed_r;
   logic [15:0] stat_retries_r;

   // outcome counters follow the registered completion pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_delivered_r <= 16'd0;
         stat_failed_r    <= 16'd0;
         stat_retries_r   <= 16'd0;
      end else begin
         if (done_valid_r && done_ok_r) begin
            stat_delivered_r <= sat_inc16(stat_delivered_r);
         end
         if (done_valid_r && !done_ok_r) begin
            stat_failed_r <= sat_inc16(stat_failed_r);
         end
         if (retry_s) begin
            stat_retries_r <= sat_inc16(stat_retries_r);
         end
      end
   end

   assign bus.stat_delivered = stat_delivered_r;
   assign bus.stat_failed    = stat_failed_r;
   assign bus.stat_retries   = stat_retries_r;
`endif

endmodule

// File: tb/tb_golden_dispatch_ctrl.sv
// Directed bench for golden_dispatch_ctrl (TIMEOUT_CYCLES=64, MAX_RETRY=2).
// Cycle N is the clock period after the accept period (cycle 0); outputs sampled at negedge.
module tb_golden_dispatch_ctrl;
   import golden_logistics_pkg::*;

   logic clk;
   logic rst_n;

   int checks     = 0;
   int errors     = 0;
   int depart_cnt = 0;
   int done_cnt   = 0;

   int           base_dep;
   int           base_done;
   int           seen_dep;
   int           seen_done;
   int           done_cyc;
   logic         got_ok;
   logic [7:0]   got_id;
   done_status_t exp_s;

   golden_dispatch_ctrl_if #(.ID_W(8)) bus ();

   golden_dispatch_ctrl #(
      .ID_W           (8),
      .TIMEOUT_CYCLES (64),
      .MAX_RETRY      (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // pulse tallies, sampled at the rising edge
   always @(posedge clk) begin
      if (bus.truck_depart === 1'b1) depart_cnt <= depart_cnt + 1;
      if (bus.done_valid === 1'b1) done_cnt <= done_cnt + 1;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] id, input logic cc,
                        input logic tr, input logic dc);
      bus.order_valid        = v;
      bus.order_id           = id;
      bus.customs_cleared    = cc;
      bus.transit_ready      = tr;
      bus.delivery_confirmed = dc;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      check("rst_order_ready", bus.order_ready, 1'b1);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_customs_req", bus.customs_req, 1'b0);
      check("rst_truck_depart", bus.truck_depart, 1'b0);
      check("rst_done_valid", bus.done_valid, 1'b0);
      check("rst_done_id", bus.done_id, 8'h00);
      check("rst_done_ok", bus.done_ok, 1'b0);
`ifdef GOLDEN_DISPATCH_STATS_EN
      check("rst_stat_delivered", bus.stat_delivered, 16'd0);
      check("rst_stat_failed", bus.stat_failed, 16'd0);
      check("rst_stat_retries", bus.stat_retries, 16'd0);
`endif
      rst_n = 1'b1;

      // ideal path: every input high, order 2A
      exp_s = '{id: 8'h2A, ok: 1'b1};
      drive(1'b1, 8'h2A, 1'b1, 1'b1, 1'b1);
      check("ideal_c0_ready", bus.order_ready, 1'b1);
      tick();
      bus.order_valid = 1'b0;
      check("ideal_c1_busy", bus.busy, 1'b1);
      check("ideal_c1_ready", bus.order_ready, 1'b0);
      check("ideal_c1_customs_req", bus.customs_req, 1'b1);
      tick();
      check("ideal_c2_no_depart", bus.truck_depart, 1'b0);
      tick();
      check("ideal_c3_depart", bus.truck_depart, 1'b1);
      check("ideal_c3_no_done", bus.done_valid, 1'b0);
      tick();
      check("ideal_c4_done_valid", bus.done_valid, 1'b1);
      check("ideal_c4_done_id", bus.done_id, exp_s.id);
      check("ideal_c4_done_ok", bus.done_ok, exp_s.ok);
      check("ideal_c4_customs_req", bus.customs_req, 1'b0);
      check("ideal_c4_depart_low", bus.truck_depart, 1'b0);
      tick();
      check("ideal_c5_ready", bus.order_ready, 1'b1);
      check("ideal_c5_busy", bus.busy, 1'b0);
      check("ideal_c5_done_low", bus.done_valid, 1'b0);

      // customs revoked while waiting for a carrier
      drive(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
      tick();
      bus.order_valid = 1'b0;
      tick();
      check("revoke_c2_customs_req", bus.customs_req, 1'b1);
      bus.customs_cleared = 1'b0;
      tick();
      bus.transit_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("revoke_hold_no_depart", bus.truck_depart, 1'b0);
         check("revoke_hold_customs_req", bus.customs_req, 1'b1);
      end
      bus.customs_cleared = 1'b1;
      tick();
      check("revoke_c7_no_depart", bus.truck_depart, 1'b0);
      tick();
      check("revoke_c8_depart", bus.truck_depart, 1'b1);
      bus.delivery_confirmed = 1'b1;
      tick();
      check("revoke_done_valid", bus.done_valid, 1'b1);
      check("revoke_done_id", bus.done_id, 8'h11);
      check("revoke_done_ok", bus.done_ok, 1'b1);
      bus.delivery_confirmed = 1'b0;
      tick();

      // one timeout then confirmation during the second attempt
      drive(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
      tick();
      bus.order_valid = 1'b0;
      tick();
      tick();
      check("retry_first_launch", bus.truck_depart, 1'b1);
      seen_dep  = 0;
      seen_done = 0;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (bus.truck_depart === 1'b1) seen_dep++;
         if (bus.done_valid === 1'b1) seen_done++;
      end
      check("retry_quiet_departs", 32'(seen_dep), 32'd0);
      check("retry_quiet_dones", 32'(seen_done), 32'd0);
      tick();
      check("retry_second_launch", bus.truck_depart, 1'b1);
      bus.delivery_confirmed = 1'b1;
      tick();
      check("retry_done_valid", bus.done_valid, 1'b1);
      check("retry_done_id", bus.done_id, 8'h33);
      check("retry_done_ok", bus.done_ok, 1'b1);
      bus.delivery_confirmed = 1'b0;
      tick();
      check("retry_idle", bus.order_ready, 1'b1);

      // retries exhausted: launches at cycles 3, 68, 133, failure report at 197
      drive(1'b1, 8'h44, 1'b1, 1'b1, 1'b0);
      base_dep  = depart_cnt;
      base_done = done_cnt;
      done_cyc  = -1;
      got_ok    = 1'bx;
      got_id    = 8'hxx;
      for (int c = 1; c <= 400; c++) begin
         tick();
         bus.order_valid = 1'b0;
         if (bus.done_valid === 1'b1) begin
            done_cyc = c;
            got_ok   = bus.done_ok;
            got_id   = bus.done_id;
            break;
         end
      end
      check("exhaust_done_cycle", 32'(done_cyc), 32'd197);
      check("exhaust_done_ok", got_ok, 1'b0);
      check("exhaust_done_id", got_id, 8'h44);
      check("exhaust_departs", 32'(depart_cnt - base_dep), 32'd3);
      tick();
      check("exhaust_single_done", bus.done_valid, 1'b0);
      check("exhaust_done_count", 32'(done_cnt - base_done), 32'd1);
      check("exhaust_idle", bus.order_ready, 1'b1);

      // stale confirmation in CUSTOMS, then confirmation on the expiry cycle
      drive(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
      tick();
      bus.order_valid = 1'b0;
      tick();
      tick();
      check("stale_no_done", bus.done_valid, 1'b0);
      check("stale_busy", bus.busy, 1'b1);
      check("stale_customs_req", bus.customs_req, 1'b1);
      bus.delivery_confirmed = 1'b0;
      bus.customs_cleared    = 1'b1;
      tick();
      tick();
      check("simul_launch", bus.truck_depart, 1'b1);
      base_dep = depart_cnt;
      for (int i = 0; i < 63; i++) tick();
      bus.delivery_confirmed = 1'b1;
      tick();
      check("simul_done_valid", bus.done_valid, 1'b1);
      check("simul_done_ok", bus.done_ok, 1'b1);
      check("simul_no_redepart", bus.truck_depart, 1'b0);
      bus.delivery_confirmed = 1'b0;
      tick();
      check("simul_depart_count", 32'(depart_cnt - base_dep), 32'd1);
`ifdef GOLDEN_DISPATCH_STATS_EN
      check("stat_delivered_4", bus.stat_delivered, 16'd4);
      check("stat_failed_1", bus.stat_failed, 16'd1);
      check("stat_retries_3", bus.stat_retries, 16'd3);
`endif

      // reset while in transit aborts the order without a report
      drive(1'b1, 8'h66, 1'b1, 1'b1, 1'b0);
      tick();
      bus.order_valid = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check("abort_in_transit_busy", bus.busy, 1'b1);
      base_done = done_cnt;
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_async_busy", bus.busy, 1'b0);
      check("abort_async_ready", bus.order_ready, 1'b1);
      check("abort_async_customs_req", bus.customs_req, 1'b0);
      check("abort_async_depart", bus.truck_depart, 1'b0);
      check("abort_async_done_valid", bus.done_valid, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      bus.delivery_confirmed = 1'b1;
      tick();
      check("abort_no_done", 32'(done_cnt - base_done), 32'd0);
`ifdef GOLDEN_DISPATCH_STATS_EN
      check("abort_stat_delivered", bus.stat_delivered, 16'd0);
      check("abort_stat_failed", bus.stat_failed, 16'd0);
      check("abort_stat_retries", bus.stat_retries, 16'd0);
`endif
      drive(1'b1, 8'h05, 1'b1, 1'b1, 1'b1);
      tick();
      bus.order_valid = 1'b0;
      tick();
      tick();
      tick();
      check("after_rst_done_valid", bus.done_valid, 1'b1);
      check("after_rst_done_id", bus.done_id, 8'h05);
      check("after_rst_done_ok", bus.done_ok, 1'b1);
      tick();
      check("after_rst_idle", bus.order_ready, 1'b1);
`ifdef GOLDEN_DISPATCH_STATS_EN
      check("after_rst_stat_delivered", bus.stat_delivered, 16'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
